disp_refill_sched: RTL
======================

Name: disp_refill_sched

Overview:
Pixel-clock-domain scheduler that keeps the display read FIFO (1024x16, rdusedw[9:0]) filled from SDRAM.
- Issues burst read requests to the SDRAM controller over a 4-phase req/ack handshake and walks the frame buffer address with wrap-around.
- Primes the FIFO before display start and raises wait_scrn on a frame boundary so that the first visible pixel is frame word 0.
- Flags FIFO underruns during visible time.

Parameters:
ADDR_W, 22, width of SDRAM word address
BASE_ADDR, 0, frame buffer start word address
FRAME_WORDS, 307200, words per frame (640x480); must be a multiple of BURST_LEN
BURST_LEN, 256, words per read request
LOW_WATER, 512, request when rdusedw < LOW_WATER; LOW_WATER+BURST_LEN <= 1024 required

Ports:
pixel_clock  in  1  clock
rst_n  in  1  async reset, active low
enable  in  1  run request; level
vsync_in  in  1  active-high vertical sync from timing generator, pixel_clock domain
visible_in  in  1  FIFO rdreq from timing/display side (monitor only)
rdusedw  in  10  FIFO read-side used words
rd_req  out  1  burst read request to SDRAM domain
rd_addr  out  ADDR_W  burst start word address; stable while rd_req=1
rd_ack  in  1  SDRAM-side ack, asynchronous; rises after last burst word is written to the FIFO
wait_scrn  out  1  display enable to FIFO read/gating logic
frame_done  out  1  1-cycle pulse when address wraps to BASE_ADDR
underrun  out  1  sticky underrun flag
busy  out  1  high in any state except IDLE

Behaviour:
Reset (async): rd_req=0, rd_addr=BASE_ADDR, wait_scrn=0, frame_done=0, underrun=0, busy=0, offset=0, sync flops=0, state=IDLE, hs=H_IDLE.
- rd_ack passes through a 2-flop synchronizer (ack_s). vs_rise = vsync_in & ~vsync_d (vsync_d is one registered stage).
- Main FSM:
  - IDLE: when enable=1 -> WAIT_VS.
  - WAIT_VS: on vs_rise -> offset=0 -> PRIME.
  - PRIME: when rdusedw >= LOW_WATER and hs=H_IDLE -> ARMED.
  - ARMED: on vs_rise -> wait_scrn=1 -> RUN.
  - RUN: steady state.
  - Any state with enable=0: wait_scrn=0 on the next edge; a handshake in flight completes (H_REQ/H_REL are never aborted); FSM enters IDLE once hs=H_IDLE.
- Handshake sub-FSM, active in PRIME/ARMED/RUN:
  - H_IDLE: if rdusedw < LOW_WATER -> rd_req=1, rd_addr=BASE_ADDR+offset -> H_REQ. Evaluated one cycle after return to H_IDLE, so rdusedw reflects the completed burst.
  - H_REQ: hold rd_req and rd_addr. On ack_s=1: rd_req=0, advance offset -> H_REL.
  - H_REL: on ack_s=0 -> H_IDLE.
  - At most one burst in flight. rd_req never rises while ack_s=1.
- Offset advance: if offset+BURST_LEN == FRAME_WORDS then offset=0 and frame_done pulses for 1 cycle; else offset += BURST_LEN. Compute at ADDR_W width with no truncation.
- Minimum request-to-request spacing: 2 sync + 1 edge for the rise, 2 sync + 1 edge for the fall, plus the 1-cycle H_IDLE.
- Underrun: in RUN, visible_in=1 and rdusedw=0 sets underrun. It is cleared only by rst_n or by an IDLE->WAIT_VS transition.
- vs_rise in PRIME is ignored; wait_scrn rises only from ARMED.
- Refill continues across frame wrap with no gap. The next frame's words follow contiguously.
- Simultaneous events:
  - enable fall together with vs_rise in ARMED: enable wins, wait_scrn stays 0.
  - ack_s rise together with enable fall: offset still advances.

Test Plan:
1. Reset mid-burst (rd_req=1), rst_n low 3 cycles -> all outputs 0 and rd_addr=BASE_ADDR immediately (async), no request until enable and the next vs_rise.
2. FRAME_WORDS=1024, BURST_LEN=256, LOW_WATER=512, FIFO model acking after 256 writes; enable, vsync pulse -> requests at addr 0 then 256; PRIME->ARMED once rdusedw=512; wait_scrn=1 exactly 1 cycle after the next vs_rise edge.
3. Steady state with visible_in draining 1 word/cycle -> rd_addr sequence 512, 768, 0, 256; frame_done high for exactly 1 cycle on the 768->0 advance.
4. rdusedw forced 0 while visible_in=1 in RUN -> underrun=1 and stays 1; unchanged by visible_in=1 with rdusedw=0 in PRIME.
5. enable dropped while in H_REQ -> rd_req held until ack_s=1, then released; wait_scrn=0 on the next edge; IDLE reached after ack falls; busy=0.
6. rd_ack held high 10 cycles, rdusedw=100 -> rd_req stays 0 until 2 cycles after ack falls plus the H_IDLE cycle; never two overlapping requests.

Source files
------------

// File: rtl/disp_refill_sched.sv
// Keeps the display read FIFO topped up from SDRAM with one burst request in flight at a time.
// It primes the FIFO after vsync and starts the screen on a frame boundary.
module disp_refill_sched #(
    parameter int ADDR_W      = 22,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 256,
    parameter int LOW_WATER   = 512
) (
    input  logic              pixel_clock,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vsync_in,
    input  logic              visible_in,
    input  logic [9:0]        rdusedw,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              wait_scrn,
    output logic              frame_done,
    output logic              underrun,
    output logic              busy
);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);
    localparam logic [AW1-1:0]    BURST_W = AW1'(BURST_LEN);
    localparam logic [AW1-1:0]    FRAME_W = AW1'(FRAME_WORDS);
    localparam logic [10:0]       LOW_W   = 11'(LOW_WATER);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_PRIME, S_ARMED, S_RUN} state_t;
    typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} hs_t;

    state_t            state_q, state_d;
    hs_t               hs_q, hs_d;
    logic              ack_m_q, ack_m_d, ack_s_q, ack_s_d;
    logic              vsync_dly_q, vsync_dly_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_req_q, rd_req_d;
    logic              wait_scrn_q, wait_scrn_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q, underrun_d;

    logic              vs_rise;
    logic              fifo_low;
    logic              hs_active;
    logic [AW1-1:0]    offset_next;

    assign vs_rise     = vsync_in & ~vsync_dly_q;
    assign fifo_low    = {1'b0, rdusedw} < LOW_W;
    assign hs_active   = (state_q == S_PRIME) || (state_q == S_ARMED) || (state_q == S_RUN);
    // One extra bit so the wrap compare sees the true sum.
    assign offset_next = {1'b0, offset_q} + BURST_W;

    always_comb begin
        state_d      = state_q;
        hs_d         = hs_q;
        ack_m_d      = rd_ack;
        ack_s_d      = ack_m_q;
        vsync_dly_d  = vsync_in;
        offset_d     = offset_q;
        rd_addr_d    = rd_addr_q;
        rd_req_d     = rd_req_q;
        wait_scrn_d  = wait_scrn_q;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;

        // A started handshake always runs to completion; only new requests need enable.
        case (hs_q)
            H_IDLE: begin
                if (enable && hs_active && fifo_low && !ack_s_q) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = BASE_W + offset_q;
                    hs_d      = H_REQ;
                end
            end
            H_REQ: begin
                if (ack_s_q) begin
                    rd_req_d = 1'b0;
                    hs_d     = H_REL;
                    if (offset_next == FRAME_W) begin
                        offset_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        offset_d = offset_next[ADDR_W-1:0];
                    end
                end
            end
            H_REL: begin
                if (!ack_s_q) begin
                    hs_d = H_IDLE;
                end
            end
            default: hs_d = H_IDLE;
        endcase

        if (!enable) begin
            wait_scrn_d = 1'b0;
            if (hs_q == H_IDLE) begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_WAIT_VS;
                    underrun_d = 1'b0;
                end
                S_WAIT_VS: begin
                    if (vs_rise) begin
                        offset_d = '0;
                        state_d  = S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (!fifo_low && hs_q == H_IDLE) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (vs_rise) begin
                        wait_scrn_d = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_q == S_RUN && visible_in && rdusedw == '0) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hs_q         <= H_IDLE;
            ack_m_q      <= 1'b0;
            ack_s_q      <= 1'b0;
            vsync_dly_q  <= 1'b0;
            offset_q     <= '0;
            rd_addr_q    <= BASE_W;
            rd_req_q     <= 1'b0;
            wait_scrn_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            ack_m_q      <= ack_m_d;
            ack_s_q      <= ack_s_d;
            vsync_dly_q  <= vsync_dly_d;
            offset_q     <= offset_d;
            rd_addr_q    <= rd_addr_d;
            rd_req_q     <= rd_req_d;
            wait_scrn_q  <= wait_scrn_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign wait_scrn  = wait_scrn_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule
